// File: rtl/spm_port_arbiter_pkg.sv
// spm_port_arbiter_pkg
//   Shared definitions for the scratch-pad port arbiter:
//   - default bus widths and the starvation limit
//   - active-low strobe levels (ENABLE_/DISABLE_) and READ/WRITE values
//   - owner encoding for the outstanding-read tracker
//   - grant decision encoding produced by spm_port_arbiter_grant
package spm_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 30;
  localparam int DATA_W_DEF     = 32;
  localparam int SPM_ADDR_W_DEF = 12;
  localparam int STARVE_MAX_DEF = 3;

  // Strobes are active low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    OWNER_NONE   = 2'd0,
    OWNER_IF_RD  = 2'd1,
    OWNER_MEM_RD = 2'd2
  } owner_e;

  // Which requester drives the SPM port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_MEM  = 2'd2
  } grant_e;

endpackage

// File: rtl/spm_port_arbiter_if.sv
// spm_port_arbiter_if
//   One requester port of the scratch-pad arbiter (used once for IF, once for MEM).
//   master : requester side (drives as_, rw, addr, wr_data; sees rd_data, rd_vld, busy)
//   slave  : arbiter side
//   as_     strobe, active low
//   rw      1 = read, 0 = write
//   addr    word address
//   wr_data write data
//   rd_data read data, meaningful while rd_vld = 1
//   rd_vld  one-cycle read-data-valid pulse
//   busy    request not accepted this cycle; requester must hold it
interface spm_port_arbiter_if
  import spm_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic              busy;

  modport master (
    output as_, rw, addr, wr_data,
    input  rd_data, rd_vld, busy
  );

  modport slave (
    input  as_, rw, addr, wr_data,
    output rd_data, rd_vld, busy
  );

endinterface

// File: rtl/spm_port_arbiter_grant.sv
// spm_port_arbiter_grant
//   Combinational grant decision for the shared SPM port.
//   MEM has fixed priority over IF unless IF has been starved for the
//   maximum number of cycles, in which case IF wins this one cycle.
//   if_req      IF requests this cycle (already qualified by reset)
//   mem_req     MEM requests this cycle (already qualified by reset)
//   if_starved  starvation counter has reached its limit
//   gnt         winning requester or GNT_NONE
module spm_port_arbiter_grant
  import spm_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   mem_req,
  input  logic   if_starved,
  output grant_e gnt
);

  // Priority decision with starvation override.
  always_comb begin
    gnt = GNT_NONE;
    case ({if_req, mem_req})
      2'b10: gnt = GNT_IF;
      2'b01: gnt = GNT_MEM;
      2'b11: begin
        if (if_starved) begin
          gnt = GNT_IF;
        end else begin
          gnt = GNT_MEM;
        end
      end
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/spm_port_arbiter.sv
// spm_port_arbiter
//   Shares one single-ported scratch-pad memory between the IF and MEM stages.
//   One requester is granted per cycle; the loser gets busy and must hold its
//   request. Read data returns one cycle after the grant and is steered to the
//   requester that owned the read, with a one-cycle valid pulse.
//   clk, reset    clock; synchronous active-high reset
//   if_port       IF requester port (slave side)
//   mem_port      MEM requester port (slave side)
//   spm_as_       SPM strobe, active low
//   spm_rw        SPM read/write
//   spm_addr      SPM word address (low bits of the granted address)
//   spm_wr_data   SPM write data
//   spm_rd_data   SPM read data, valid the cycle after a read strobe
module spm_port_arbiter
  import spm_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SPM_ADDR_W = SPM_ADDR_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  spm_port_arbiter_if.slave     if_port,
  spm_port_arbiter_if.slave     mem_port,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic [DATA_W-1:0]     spm_wr_data,
  input  logic [DATA_W-1:0]     spm_rd_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic              if_req_s;
  logic              mem_req_s;
  logic              if_starved_s;
  grant_e            gnt_s;
  owner_e            owner_r;
  owner_e            owner_nxt_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [ADDR_W-1:0] gnt_addr_s;
  logic              unused_addr_s;

  // Requests are ignored while reset is held so the port stays quiet.
  assign if_req_s     = !reset && (if_port.as_ == ENABLE_);
  assign mem_req_s    = !reset && (mem_port.as_ == ENABLE_);
  assign if_starved_s = (starve_cnt_r == CNT_W'(STARVE_MAX));

  spm_port_arbiter_grant u_grant (
    .if_req     (if_req_s),
    .mem_req    (mem_req_s),
    .if_starved (if_starved_s),
    .gnt        (gnt_s)
  );

  // Forward the granted request to the SPM and pick the next read owner.
  always_comb begin
    spm_as_     = DISABLE_;
    spm_rw      = WRITE;
    gnt_addr_s  = '0;
    spm_wr_data = '0;
    owner_nxt_s = OWNER_NONE;
    case (gnt_s)
      GNT_IF: begin
        spm_as_     = ENABLE_;
        spm_rw      = if_port.rw;
        gnt_addr_s  = if_port.addr;
        spm_wr_data = if_port.wr_data;
        owner_nxt_s = (if_port.rw == READ) ? OWNER_IF_RD : OWNER_NONE;
      end
      GNT_MEM: begin
        spm_as_     = ENABLE_;
        spm_rw      = mem_port.rw;
        gnt_addr_s  = mem_port.addr;
        spm_wr_data = mem_port.wr_data;
        owner_nxt_s = (mem_port.rw == READ) ? OWNER_MEM_RD : OWNER_NONE;
      end
      default: begin
        owner_nxt_s = OWNER_NONE;
      end
    endcase
  end

  // The SPM only decodes the low address bits; the rest are deliberately dropped.
  assign spm_addr      = gnt_addr_s[SPM_ADDR_W-1:0];
  assign unused_addr_s = ^gnt_addr_s[ADDR_W-1:SPM_ADDR_W];

  // Busy goes only to a requester that strobes and loses.
  assign if_port.busy  = if_req_s && (gnt_s != GNT_IF);
  assign mem_port.busy = mem_req_s && (gnt_s != GNT_MEM);

  // Steer last cycle's read data to its owner; suppressed during reset.
  always_comb begin
    if_port.rd_data  = '0;
    if_port.rd_vld   = 1'b0;
    mem_port.rd_data = '0;
    mem_port.rd_vld  = 1'b0;
    if (!reset) begin
      case (owner_r)
        OWNER_IF_RD: begin
          if_port.rd_data = spm_rd_data;
          if_port.rd_vld  = 1'b1;
        end
        OWNER_MEM_RD: begin
          mem_port.rd_data = spm_rd_data;
          mem_port.rd_vld  = 1'b1;
        end
        default: begin
          if_port.rd_vld  = 1'b0;
          mem_port.rd_vld = 1'b0;
        end
      endcase
    end else begin
      if_port.rd_vld  = 1'b0;
      mem_port.rd_vld = 1'b0;
    end
  end

  // Read-owner tracker and saturating IF starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r      <= OWNER_NONE;
      starve_cnt_r <= '0;
    end else begin
      owner_r <= owner_nxt_s;
      if (if_req_s && (gnt_s != GNT_IF)) begin
        if (if_starved_s) begin
          starve_cnt_r <= starve_cnt_r;
        end else begin
          starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end
      end else begin
        starve_cnt_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spm_port_arbiter.sv
// tb_spm_port_arbiter
//   Directed vector table (one row per clock cycle) plus a hand-written
//   continuous-contention sequence for the spm_port_arbiter.
module tb_spm_port_arbiter;
  import spm_port_arbiter_pkg::*;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int SAW  = 12;
  localparam int SMAX = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           spm_as_;
  logic           spm_rw;
  logic [SAW-1:0] spm_addr;
  logic [DW-1:0]  spm_wr_data;
  logic [DW-1:0]  spm_rd_data;

  int errors = 0;
  int checks = 0;

  spm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_bus ();
  spm_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  spm_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .SPM_ADDR_W(SAW), .STARVE_MAX(SMAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_port     (if_bus),
    .mem_port    (mem_bus),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_addr    (spm_addr),
    .spm_wr_data (spm_wr_data),
    .spm_rd_data (spm_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rst;
    logic           ias;
    logic           irw;
    logic [AW-1:0]  iaddr;
    logic [DW-1:0]  iwd;
    logic           mas;
    logic           mrw;
    logic [AW-1:0]  maddr;
    logic [DW-1:0]  mwd;
    logic [DW-1:0]  srd;
    logic           eas;
    logic           erw;
    logic [SAW-1:0] eaddr;
    logic [DW-1:0]  ewd;
    logic           eib;
    logic           emb;
    logic           eiv;
    logic [DW-1:0]  eid;
    logic           emv;
    logic [DW-1:0]  emd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic rst, input logic ias, input logic irw, input logic [AW-1:0] iaddr,
    input logic [DW-1:0] iwd, input logic mas, input logic mrw, input logic [AW-1:0] maddr,
    input logic [DW-1:0] mwd, input logic [DW-1:0] srd,
    input logic eas, input logic erw, input logic [SAW-1:0] eaddr, input logic [DW-1:0] ewd,
    input logic eib, input logic emb, input logic eiv, input logic [DW-1:0] eid,
    input logic emv, input logic [DW-1:0] emd);
    vec_t v;
    v.rst = rst; v.ias = ias; v.irw = irw; v.iaddr = iaddr; v.iwd = iwd;
    v.mas = mas; v.mrw = mrw; v.maddr = maddr; v.mwd = mwd; v.srd = srd;
    v.eas = eas; v.erw = erw; v.eaddr = eaddr; v.ewd = ewd;
    v.eib = eib; v.emb = emb; v.eiv = eiv; v.eid = eid; v.emv = emv; v.emd = emd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    reset           = v.rst;
    if_bus.as_      = v.ias;
    if_bus.rw       = v.irw;
    if_bus.addr     = v.iaddr;
    if_bus.wr_data  = v.iwd;
    mem_bus.as_     = v.mas;
    mem_bus.rw      = v.mrw;
    mem_bus.addr    = v.maddr;
    mem_bus.wr_data = v.mwd;
    spm_rd_data     = v.srd;
  endtask

  task automatic check(input string name, input int idx, input vec_t v);
    logic [113:0] act;
    logic [113:0] exp;
    act = {spm_as_, spm_rw, spm_addr, spm_wr_data, if_bus.busy, mem_bus.busy,
           if_bus.rd_vld, if_bus.rd_data, mem_bus.rd_vld, mem_bus.rd_data};
    exp = {v.eas, v.erw, v.eaddr, v.ewd, v.eib, v.emb, v.eiv, v.eid, v.emv, v.emd};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got as_=%b rw=%b addr=%h wd=%h busy=%b/%b if_vld=%b if_rd=%h mem_vld=%b mem_rd=%h; want as_=%b rw=%b addr=%h wd=%h busy=%b/%b if_vld=%b if_rd=%h mem_vld=%b mem_rd=%h",
               name, idx, act[113], act[112], act[111:100], act[99:68], act[67], act[66],
               act[65], act[64:33], act[32], act[31:0],
               v.eas, v.erw, v.eaddr, v.ewd, v.eib, v.emb, v.eiv, v.eid, v.emv, v.emd);
    end
  endtask

  initial begin
    vec_t v;
    logic prev_if_gnt;

    reset = 1'b1;
    if_bus.as_ = 1'b1;  if_bus.rw = 1'b1;  if_bus.addr = '0;  if_bus.wr_data = '0;
    mem_bus.as_ = 1'b1; mem_bus.rw = 1'b1; mem_bus.addr = '0; mem_bus.wr_data = '0;
    spm_rd_data = '0;

    // rst ias irw iaddr iwd | mas mrw maddr mwd | srd || eas erw eaddr ewd | ib mb | iv id | mv md
    // Reset held with both strobes low, then release: MEM first, IF every 4th.
    add(1'b1, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h0,        1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b1, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h0,        1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h0,        1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0001, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'haaaa0001);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0002, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'haaaa0002);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0003, 1'b0,1'b1,12'h020,32'h0, 1'b0,1'b1, 1'b0,32'h0, 1'b1,32'haaaa0003);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0004, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b1,32'haaaa0004, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0005, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'haaaa0005);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0006, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'haaaa0006);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'haaaa0007, 1'b0,1'b1,12'h020,32'h0, 1'b0,1'b1, 1'b0,32'h0, 1'b1,32'haaaa0007);
    add(1'b0, 1'b1,1'b1,30'h20,32'h0, 1'b1,1'b1,30'h10,32'h0, 32'h0c0c0c0c, 1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b1,32'h0c0c0c0c, 1'b0,32'h0);
    // IF-only read; upper address bits must not reach the SPM.
    add(1'b0, 1'b0,1'b1,30'h30000001,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h11111111, 1'b0,1'b1,12'h001,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h0c008000,   1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b1,32'h0c008000, 1'b0,32'h0);
    // MEM write, then no response.
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b0,1'b0,30'h154,32'h0041a4d9, 32'h22222222, 1'b0,1'b0,12'h154,32'h0041a4d9, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h33333333,   1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    // IF write loses to MEM read, is held and then granted.
    add(1'b0, 1'b0,1'b0,30'h0ff,32'hdeadbeef, 1'b0,1'b1,30'h200,32'h0, 32'h0, 1'b0,1'b1,12'h200,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b0,30'h0ff,32'hdeadbeef, 1'b1,1'b1,30'h0,32'h0, 32'h44444444, 1'b0,1'b0,12'h0ff,32'hdeadbeef, 1'b0,1'b0, 1'b0,32'h0, 1'b1,32'h44444444);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h55555555,   1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    // Alternating owners on consecutive cycles.
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h0,          1'b0,1'b1,12'h010,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h10,         1'b0,1'b1,12'h020,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b1,32'h10);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h20,         1'b0,1'b1,12'h010,32'h0, 1'b0,1'b0, 1'b1,32'h20, 1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h10,          1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b1,32'h10);
    // Reset right after a granted IF read drops the pending data.
    add(1'b0, 1'b0,1'b1,30'h30,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h0,          1'b0,1'b1,12'h030,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b1, 1'b0,1'b1,30'h30,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h66666666,   1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h77777777,    1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    // Reset with starvation count at 2: afterwards IF must wait a full 3 denials again.
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h0,        1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h5a5a0001, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'h5a5a0001);
    add(1'b1, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h5a5a0002, 1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h5a5a0003, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b0,32'h0);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h5a5a0004, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'h5a5a0004);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h5a5a0005, 1'b0,1'b1,12'h010,32'h0, 1'b1,1'b0, 1'b0,32'h0, 1'b1,32'h5a5a0005);
    add(1'b0, 1'b0,1'b1,30'h20,32'h0, 1'b0,1'b1,30'h10,32'h0, 32'h5a5a0006, 1'b0,1'b1,12'h020,32'h0, 1'b0,1'b1, 1'b0,32'h0, 1'b1,32'h5a5a0006);
    add(1'b0, 1'b1,1'b1,30'h0,32'h0, 1'b1,1'b1,30'h0,32'h0, 32'h5a5a0007,    1'b1,1'b0,12'h000,32'h0, 1'b0,1'b0, 1'b1,32'h5a5a0007, 1'b0,32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check("vec", i, vecs[i]);
    end

    // Continuous contention from an idle, unstarved state: IF wins on every
    // 4th cycle and each cycle's data goes to the previous cycle's winner.
    prev_if_gnt = 1'b0;
    for (int k = 0; k < 12; k++) begin
      v.rst = 1'b0;
      v.ias = 1'b0; v.irw = 1'b1; v.iaddr = 30'h3ab; v.iwd = 32'h0;
      v.mas = 1'b0; v.mrw = 1'b1; v.maddr = 30'h0c4; v.mwd = 32'h0;
      v.srd = 32'hc0de0000 + 32'(k);
      v.eas = 1'b0; v.erw = 1'b1; v.ewd = 32'h0;
      if ((k % 4) == 3) begin
        v.eaddr = 12'h3ab; v.eib = 1'b0; v.emb = 1'b1;
      end else begin
        v.eaddr = 12'h0c4; v.eib = 1'b1; v.emb = 1'b0;
      end
      if (k == 0) begin
        v.eiv = 1'b0; v.eid = 32'h0; v.emv = 1'b0; v.emd = 32'h0;
      end else if (prev_if_gnt) begin
        v.eiv = 1'b1; v.eid = v.srd; v.emv = 1'b0; v.emd = 32'h0;
      end else begin
        v.eiv = 1'b0; v.eid = 32'h0; v.emv = 1'b1; v.emd = v.srd;
      end
      @(negedge clk);
      drive(v);
      #1;
      check("contend", k, v);
      prev_if_gnt = ((k % 4) == 3);
    end

    @(negedge clk);
    if_bus.as_  = 1'b1;
    mem_bus.as_ = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
